// File: rtl/am4_plr_if.sv
// Bus bundle between the M4 microsequencer/control store and the pipeline register.
// The master modport drives the control store word and the sequencer strobes.
interface am4_plr_if #(
    parameter int unsigned AM4_ADDR_WIDTH = 10,
    parameter int unsigned AM4_UW_WIDTH   = 40
);
    localparam int unsigned Aw  = AM4_ADDR_WIDTH;
    localparam int unsigned UfW = AM4_UW_WIDTH - 12 - AM4_ADDR_WIDTH;

    logic [AM4_UW_WIDTH-1:0] mc;
    logic                    mc_par;
    logic [13:0]             cond;
    logic                    wrdy;
    logic                    ctl_n;
    logic                    cte_n;
    logic                    ena;
    logic [3:0]              i;
    logic                    tst;
    logic [Aw-1:0]           d;
    logic                    re_n;
    logic                    za_n;
    logic [UfW-1:0]          uf;
    logic [Aw-1:0]           cnt;
    logic                    wst;
    logic                    tmo;
    logic                    perr;

    modport master (
        output mc, mc_par, cond, wrdy, ctl_n, cte_n,
        input  ena, i, tst, d, re_n, za_n, uf, cnt, wst, tmo, perr
    );

    modport slave (
        input  mc, mc_par, cond, wrdy, ctl_n, cte_n,
        output ena, i, tst, d, re_n, za_n, uf, cnt, wst, tmo, perr
    );
endinterface

// File: rtl/am4_plr.sv
// M4 microinstruction pipeline register: field decode, loop counter, condition
// select and wait-state clock enable. Optional parity check: AM4_PLR_PARITY_EN.
module am4_plr #(
    parameter int unsigned AM4_ADDR_WIDTH = 10,
    parameter int unsigned AM4_UW_WIDTH   = 40,
    parameter int unsigned AM4_WAIT_TMO   = 255
) (
    input logic        clk,
    input logic        rst,
    am4_plr_if.slave   bus
);
    localparam int unsigned Aw = AM4_ADDR_WIDTH;
    localparam int unsigned Uw = AM4_UW_WIDTH;

    typedef enum logic [1:0] {StRun, StWait, StTmo} state_e;

    state_e        state_q, state_d;
    logic [Uw-1:0] pr_q, pr_d;
    logic [Aw-1:0] cnt_q, cnt_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          tmo_q, tmo_d;
    logic          ena;
    logic          wst;

    logic [3:0]    cc;
    logic          pol;
    logic          wt;
    logic [15:0]   sel_vec;

    assign cc      = pr_q[7:4];
    assign pol     = pr_q[8];
    assign wt      = pr_q[9];
    assign sel_vec = {bus.cond, (cnt_q != '0), 1'b1};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;
        ena     = 1'b1;
        wst     = 1'b0;
        case (state_q)
            StRun: begin
                // wrdy already high alongside the wt word means no stall at all
                if (wt && !bus.wrdy) begin
                    ena     = 1'b0;
                    state_d = StWait;
                    wcnt_d  = 8'd1;
                end
            end
            StWait: begin
                wst = 1'b1;
                if (bus.wrdy) begin
                    state_d = StRun;
                end else begin
                    ena = 1'b0;
                    if (wcnt_q == 8'(AM4_WAIT_TMO)) begin
                        state_d = StTmo;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            StTmo: begin
                tmo_d   = 1'b1;
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        pr_d  = pr_q;
        cnt_d = cnt_q;
        if (ena) begin
            pr_d = bus.mc;
            if (!bus.ctl_n) begin
                cnt_d = pr_q[12 +: Aw];
            end else if (!bus.cte_n) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pr_q    <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef AM4_PLR_PARITY_EN
    logic perr_q, perr_d;

    // Odd parity over word plus parity bit; the bad word is still loaded.
    always_comb begin
        perr_d = perr_q;
        if (ena && !(^{bus.mc, bus.mc_par})) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.perr = perr_q;
`else
    logic unused_mc_par;
    assign unused_mc_par = bus.mc_par;
    assign bus.perr      = 1'b0;
`endif

    assign bus.ena  = ena;
    assign bus.wst  = wst;
    assign bus.tmo  = tmo_q;
    assign bus.cnt  = cnt_q;
    assign bus.i    = pr_q[3:0];
    assign bus.za_n = pr_q[10];
    assign bus.re_n = pr_q[11];
    assign bus.d    = pr_q[12 +: Aw];
    assign bus.uf   = pr_q[Uw-1:12+Aw];
    assign bus.tst  = sel_vec[cc] ^ pol;
endmodule

// File: tb/tb_am4_plr.sv
// Self-checking bench for am4_plr: table of per-cycle vectors through a scoreboard,
// plus hand sequences for wait release, timeout, reset during wait and parity.
module tb_am4_plr;
    localparam int unsigned Aw  = 10;
    localparam int unsigned Uw  = 40;
    localparam int unsigned Tmo = 6;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    am4_plr_if #(.AM4_ADDR_WIDTH(Aw), .AM4_UW_WIDTH(Uw)) bus ();

    am4_plr #(
        .AM4_ADDR_WIDTH(Aw),
        .AM4_UW_WIDTH  (Uw),
        .AM4_WAIT_TMO  (Tmo)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  i;
        logic [3:0]  cc;
        logic        pol;
        logic [9:0]  d;
        logic [17:0] uf;
        logic        ctl_n;
        logic        cte_n;
        logic [13:0] cond;
        logic [9:0]  ecnt;
        logic        etst;
    } vec_t;

    typedef struct {
        logic [3:0]  i;
        logic [9:0]  d;
        logic [17:0] uf;
        logic [9:0]  cnt;
        logic        tst;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    function automatic logic [39:0] mkw(input logic [3:0] i, input logic [3:0] cc,
                                        input logic pol, input logic wt,
                                        input logic [9:0] d, input logic [17:0] uf);
        return {uf, d, 1'b1, 1'b1, wt, pol, cc, i};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [39:0] w);
        bus.mc     = w;
        bus.mc_par = ~(^w);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   nlow;
        int   nwst;
        exp_t e;

        vecs[0]  = '{4'h2, 4'd1,  1'b0, 10'h003, 18'h15555, 1'b1, 1'b1, 14'h0000, 10'h000, 1'b0};
        vecs[1]  = '{4'h2, 4'd1,  1'b0, 10'h003, 18'h15555, 1'b0, 1'b1, 14'h0000, 10'h003, 1'b1};
        vecs[2]  = '{4'h2, 4'd1,  1'b0, 10'h003, 18'h15555, 1'b1, 1'b0, 14'h0000, 10'h002, 1'b1};
        vecs[3]  = '{4'h2, 4'd1,  1'b0, 10'h003, 18'h15555, 1'b1, 1'b0, 14'h0000, 10'h001, 1'b1};
        vecs[4]  = '{4'h2, 4'd1,  1'b0, 10'h003, 18'h15555, 1'b1, 1'b0, 14'h0000, 10'h000, 1'b0};
        vecs[5]  = '{4'h2, 4'd1,  1'b0, 10'h003, 18'h15555, 1'b1, 1'b0, 14'h0000, 10'h3FF, 1'b1};
        vecs[6]  = '{4'h4, 4'd0,  1'b1, 10'h005, 18'h2AAAA, 1'b0, 1'b0, 14'h0000, 10'h003, 1'b0};
        vecs[7]  = '{4'h9, 4'd2,  1'b0, 10'h2AA, 18'h3FFFF, 1'b0, 1'b1, 14'h0001, 10'h005, 1'b1};
        vecs[8]  = '{4'hE, 4'd15, 1'b1, 10'h155, 18'h00001, 1'b1, 1'b1, 14'h2000, 10'h005, 1'b0};
        vecs[9]  = '{4'hF, 4'd15, 1'b0, 10'h000, 18'h00000, 1'b1, 1'b1, 14'h1FFF, 10'h005, 1'b0};
        vecs[10] = '{4'h1, 4'd9,  1'b0, 10'h3FF, 18'h00F0F, 1'b1, 1'b1, 14'h0080, 10'h005, 1'b1};
        vecs[11] = '{4'h3, 4'd1,  1'b1, 10'h3FF, 18'h0F0F0, 1'b1, 1'b1, 14'h0000, 10'h005, 1'b0};

        // Reset state
        rst       = 1'b1;
        bus.mc    = '0;
        bus.mc_par = 1'b1;
        bus.cond  = '0;
        bus.wrdy  = 1'b0;
        bus.ctl_n = 1'b1;
        bus.cte_n = 1'b1;
        #1;
        chk("rst_ena",  bus.ena,  1);
        chk("rst_i",    bus.i,    0);
        chk("rst_za_n", bus.za_n, 0);
        chk("rst_cnt",  bus.cnt,  0);
        chk("rst_tmo",  bus.tmo,  0);
        chk("rst_wst",  bus.wst,  0);
        chk("rst_perr", bus.perr, 0);
        step();
        rst = 1'b0;
        step();
        chk("rel_za_n", bus.za_n, 0);
        chk("rel_ena",  bus.ena,  1);
        chk("rel_cnt",  bus.cnt,  0);

        // Table vectors through the scoreboard
        for (int k = 0; k < 12; k++) begin
            drive(mkw(vecs[k].i, vecs[k].cc, vecs[k].pol, 1'b0, vecs[k].d, vecs[k].uf));
            bus.cond  = vecs[k].cond;
            bus.ctl_n = vecs[k].ctl_n;
            bus.cte_n = vecs[k].cte_n;
            sb.push_back('{vecs[k].i, vecs[k].d, vecs[k].uf, vecs[k].ecnt, vecs[k].etst});
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d_i", k),   bus.i,   e.i);
            chk($sformatf("v%0d_d", k),   bus.d,   e.d);
            chk($sformatf("v%0d_uf", k),  bus.uf,  e.uf);
            chk($sformatf("v%0d_cnt", k), bus.cnt, e.cnt);
            chk($sformatf("v%0d_tst", k), bus.tst, e.tst);
            chk($sformatf("v%0d_ena", k), bus.ena, 1);
        end
        chk("sb_empty", sb.size(), 0);
        bus.ctl_n = 1'b1;
        bus.cte_n = 1'b1;
        bus.cond  = '0;

        // Wait state released by wrdy five cycles after the wt word
        drive(mkw(4'h5, 4'd0, 1'b0, 1'b1, 10'h011, 18'h0));
        step();
        chk("w0_ena", bus.ena, 0);
        chk("w0_wst", bus.wst, 0);
        chk("w0_i",   bus.i,   5);
        drive(mkw(4'h6, 4'd0, 1'b0, 1'b0, 10'h000, 18'h0));
        bus.cte_n = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk($sformatf("w%0d_wst", n), bus.wst, 1);
            chk($sformatf("w%0d_ena", n), bus.ena, 0);
            chk($sformatf("w%0d_cnt", n), bus.cnt, 5);
            chk($sformatf("w%0d_i", n),   bus.i,   5);
        end
        step();
        bus.wrdy = 1'b1;
        // Second wt word right behind the release
        drive(mkw(4'h7, 4'd0, 1'b0, 1'b1, 10'h022, 18'h0));
        #1;
        chk("w5_ena", bus.ena, 1);
        chk("w5_wst", bus.wst, 1);
        step();
        bus.wrdy  = 1'b0;
        bus.cte_n = 1'b1;
        #1;
        chk("w6_i",   bus.i,   7);
        chk("w6_cnt", bus.cnt, 4);
        chk("w6_ena", bus.ena, 0);
        chk("w6_wst", bus.wst, 0);

        // Timeout path
        drive(mkw(4'h8, 4'd0, 1'b0, 1'b0, 10'h000, 18'h0));
        nlow = 0;
        nwst = 0;
        for (int n = 0; n < 20 && !bus.ena; n++) begin
            nlow++;
            if (bus.wst) nwst++;
            step();
        end
        chk("to_ena",  bus.ena, 1);
        chk("to_nlow", nlow,    7);
        chk("to_nwst", nwst,    6);
        chk("to_wst",  bus.wst, 0);
        chk("to_tmo0", bus.tmo, 0);
        chk("to_i",    bus.i,   7);
        step();
        chk("to_tmo1", bus.tmo, 1);
        chk("to_ena1", bus.ena, 1);
        chk("to_i1",   bus.i,   8);
        step();
        step();
        chk("to_sticky", bus.tmo, 1);

        // wrdy present with the wt word: no stall
        bus.wrdy = 1'b1;
        drive(mkw(4'hA, 4'd0, 1'b0, 1'b1, 10'h000, 18'h0));
        step();
        chk("ns_i",   bus.i,   4'hA);
        chk("ns_ena", bus.ena, 1);
        drive(mkw(4'hB, 4'd0, 1'b0, 1'b0, 10'h000, 18'h0));
        step();
        chk("ns_i2",  bus.i,   4'hB);
        chk("ns_wst", bus.wst, 0);
        bus.wrdy = 1'b0;

        // Word with even total parity
        bus.mc     = mkw(4'h3, 4'd0, 1'b0, 1'b0, 10'h001, 18'h0);
        bus.mc_par = ^bus.mc;
        step();
        chk("par_i", bus.i, 3);
`ifdef AM4_PLR_PARITY_EN
        chk("par_perr", bus.perr, 1);
`else
        chk("par_perr", bus.perr, 0);
`endif
        drive(mkw(4'h1, 4'd0, 1'b0, 1'b0, 10'h000, 18'h0));
        step();

        // Reset during WAIT
        drive(mkw(4'hC, 4'd0, 1'b0, 1'b1, 10'h000, 18'h0));
        step();
        step();
        chk("rw_wst", bus.wst, 1);
        rst = 1'b1;
        #1;
        chk("rw_wst0", bus.wst,  0);
        chk("rw_ena",  bus.ena,  1);
        chk("rw_i",    bus.i,    0);
        chk("rw_za_n", bus.za_n, 0);
        chk("rw_tmo",  bus.tmo,  0);
        chk("rw_perr", bus.perr, 0);
        chk("rw_cnt",  bus.cnt,  0);
        drive(mkw(4'hD, 4'd0, 1'b0, 1'b0, 10'h000, 18'h0));
        step();
        rst = 1'b0;
        step();
        chk("rw_run_i",   bus.i,   4'hD);
        chk("rw_run_ena", bus.ena, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
